gemv_udiv_16ns_8ns_seq: RTL and testbench

//  Sequential unsigned divider: the inverse of the single-cycle 8x8 unsigned multiplier in the GEMV-SIMD datapath.

---
 rtl/gemv_div_pkg.sv | 14 +
 rtl/gemv_udiv_step.sv | 19 +
 rtl/gemv_udiv_16ns_8ns_seq.sv | 122 ++++++++++++
 tb/tb_gemv_udiv_16ns_8ns_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/gemv_div_pkg.sv
// Shared widths and FSM state encoding for the GEMV-SIMD sequential unsigned divider.
package gemv_div_pkg;

    localparam int unsigned DIVIDEND_W = 16;
    localparam int unsigned DIVISOR_W  = 8;
    localparam int unsigned CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/gemv_udiv_step.sv
// One restoring radix-2 iteration: shift the next dividend bit into the partial remainder and trial-subtract.
module gemv_udiv_step
    import gemv_div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] rem,
    input  logic                 qmsb,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] rem_next,
    output logic                 qbit
);

    logic [DIVISOR_W:0] t;

    assign t        = {rem, qmsb};
    assign qbit     = (t >= {1'b0, divisor});
    // The true difference is below 2^DIVISOR_W, so the truncated subtraction is exact.
    assign rem_next = qbit ? (t[DIVISOR_W-1:0] - divisor) : t[DIVISOR_W-1:0];

endmodule

// File: rtl/gemv_udiv_16ns_8ns_seq.sv
// 16/8 unsigned restoring divider with valid/ready on both sides, one quotient bit per clock.
// Optional GEMV_UDIV_FASTPATH_EN: divide-by-zero and dividend<divisor finish on the accepting edge.
module gemv_udiv_16ns_8ns_seq
    import gemv_div_pkg::*;
(
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero
);

    state_e                state_q,     state_d;
    logic [DIVIDEND_W-1:0] q_q,         q_d;
    logic [DIVISOR_W-1:0]  rem_q,       rem_d;
    logic [DIVISOR_W-1:0]  dvs_q,       dvs_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  dz_q,        dz_d;
    logic                  in_ready_q,  in_ready_d;
    logic                  out_valid_q, out_valid_d;

    logic [DIVISOR_W-1:0]  step_rem;
    logic                  step_qbit;

    gemv_udiv_step u_step (
        .rem      (rem_q),
        .qmsb     (q_q[DIVIDEND_W-1]),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .qbit     (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    q_d     = dividend;
                    rem_d   = '0;
                    dvs_d   = divisor;
                    cnt_d   = CNT_W'(DIVIDEND_W);
                    dz_d    = (divisor == '0);
                    state_d = BUSY;
`ifdef GEMV_UDIV_FASTPATH_EN
                    // Shortcut results match what the iteration would produce.
                    if (divisor == '0) begin
                        q_d     = '1;
                        rem_d   = dividend[DIVISOR_W-1:0];
                        cnt_d   = '0;
                        state_d = DONE;
                    end else if (dividend < DIVIDEND_W'(divisor)) begin
                        q_d     = '0;
                        rem_d   = dividend[DIVISOR_W-1:0];
                        cnt_d   = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                q_d   = {q_q[DIVIDEND_W-2:0], step_qbit};
                rem_d = step_rem;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            q_q         <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            dz_q        <= dz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = q_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_gemv_udiv_16ns_8ns_seq.sv
// Self-checking bench for gemv_udiv_16ns_8ns_seq: directed cases then random operands against an arithmetic model.
module tb_gemv_udiv_16ns_8ns_seq;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    int n_checks;
    int n_fail;

    gemv_udiv_16ns_8ns_seq dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_q(input logic [15:0] a, input logic [7:0] b);
        return (b == 8'd0) ? 16'hFFFF : 16'(a / {8'd0, b});
    endfunction

    function automatic logic [7:0] model_r(input logic [15:0] a, input logic [7:0] b);
        logic [15:0] r;
        r = (b == 8'd0) ? a : (a % {8'd0, b});
        return r[7:0];
    endfunction

    function automatic int model_lat(input logic [15:0] a, input logic [7:0] b);
`ifdef GEMV_UDIV_FASTPATH_EN
        if (b == 8'd0 || a < {8'd0, b}) return 0;
`endif
        return 16;
    endfunction

    // Issue one operation from just after a rising edge, hold the result for `hold` cycles, then consume it.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b, input int hold);
        int guard;
        int lat;
        logic [15:0] eq;
        logic [7:0]  er;
        eq = model_q(a, b);
        er = model_r(a, b);
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge ap_clk); #1;
            guard++;
        end
        chk({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge ap_clk); #1;
        // Garbage operands offered while busy must be ignored.
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge ap_clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'(model_lat(a, b)));
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " in_ready_done"}, 32'(in_ready), 32'd0);
        chk({tag, " quotient"}, 32'(quotient), 32'(eq));
        chk({tag, " remainder"}, 32'(remainder), 32'(er));
        chk({tag, " div_zero"}, 32'(div_zero), 32'(b == 8'd0));
        for (int i = 0; i < hold; i++) begin
            @(posedge ap_clk); #1;
            chk({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
            chk({tag, " hold_q"}, 32'(quotient), 32'(eq));
            chk({tag, " hold_r"}, 32'(remainder), 32'(er));
        end
        out_ready = 1'b1;
        @(posedge ap_clk); #1;
        chk({tag, " consumed_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " consumed_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, " kept_q"}, 32'(quotient), 32'(eq));
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        n_checks  = 0;
        n_fail    = 0;
        ap_clk    = 1'b0;
        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        repeat (2) @(posedge ap_clk);
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset quotient", 32'(quotient), 32'd0);
        chk("reset remainder", 32'(remainder), 32'd0);
        chk("reset div_zero", 32'(div_zero), 32'd0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;

        run_op("1000/7", 16'd1000, 8'd7, 0);
        chk("1000/7 literal_q", 32'(model_q(16'd1000, 8'd7)), 32'd142);
        run_op("65535/255", 16'd65535, 8'd255, 0);
        run_op("255/1", 16'd255, 8'd1, 0);
        run_op("5/0", 16'd5, 8'd0, 0);
        run_op("3/200", 16'd3, 8'd200, 2);
        run_op("40000/13", 16'd40000, 8'd13, 5);

        // Asynchronous reset in the middle of an iteration.
        dividend  = 16'd1000;
        divisor   = 8'd7;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge ap_clk);
        #1 ap_rst_n = 1'b0;
        #1;
        chk("midreset out_valid", 32'(out_valid), 32'd0);
        chk("midreset in_ready", 32'(in_ready), 32'd1);
        chk("midreset quotient", 32'(quotient), 32'd0);
        chk("midreset remainder", 32'(remainder), 32'd0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        chk("postreset out_valid", 32'(out_valid), 32'd0);
        run_op("9/3", 16'd9, 8'd3, 0);

        for (int k = 0; k < 24; k++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 8'd0;
                1:       rb = 8'($urandom_range(1, 15));
                2:       begin rb = 8'($urandom_range(1, 255)); ra = 16'($urandom_range(0, 300)); end
                default: rb = 8'($urandom);
            endcase
            run_op("random", ra, rb, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
